// File: rtl/bram_prefetch_reader_pkg.sv
// Shared definitions for the BRAM prefetch reader: fetch/dispatch state encodings
// and the default op word width.
package BramReader_PKG;

  localparam int OP_BITS = 64;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } disp_state_t;

endpackage

// File: rtl/bram_prefetch_reader_fifo.sv
// Prefetch queue storage: circular buffer with power-of-two depth, a level counter
// and a single-cycle flush that empties it.
module prefetch_fifo
  import BramReader_PKG::*;
#(
  parameter int DATA_BITS = OP_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_BITS-1:0]         push_data,
  output logic [DATA_BITS-1:0]         head_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wrPtr;
  logic [PW-1:0]        r_rdPtr;
  logic [LW-1:0]        r_level;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wrPtr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign head_data = r_mem[r_rdPtr];
  assign level     = r_level;

endmodule

// File: rtl/bram_prefetch_reader.sv
// Prefetches op words from a BRAM FIFO controller into a small queue and hands
// them one at a time to the consumer, with pause and flush control.
module bram_prefetch_reader
  import BramReader_PKG::*;
#(
  parameter int DATA_BITS  = OP_BITS,
  parameter int DEPTH      = 4,
  parameter int LEVEL_BITS = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  is_empty,
  input  logic                  bram_rdy,
  input  logic                  bram_done,
  input  logic [DATA_BITS-1:0]  bram_data,
  output logic                  bram_trigger,
  input  logic                  reader_rdy,
  input  logic                  reader_done,
  output logic                  reader_trigger,
  output logic [DATA_BITS-1:0]  reader_data,
  input  logic                  pause,
  input  logic                  flush,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  idle
);

  localparam int FLW = $clog2(DEPTH+1);
  localparam logic [FLW-1:0] FULL_LEVEL = FLW'(DEPTH);

  fetch_state_t         r_fetchState;
  disp_state_t          r_dispState;
  logic                 r_discard;
  logic [DATA_BITS-1:0] r_readerData;

  logic                 w_active;
  logic                 w_fetch;
  logic                 w_dispatch;
  logic                 w_push;
  logic                 w_flush;
  logic [FLW-1:0]       w_level;
  logic [DATA_BITS-1:0] w_head;

  // A fetch is only launched from F_IDLE, so level plus the one outstanding read stays within DEPTH.
  assign w_active   = clk_en && !reset;
  assign w_fetch    = w_active && (r_fetchState == F_IDLE) && bram_rdy && !is_empty
                      && (w_level < FULL_LEVEL) && !flush;
  assign w_dispatch = w_active && (r_dispState == D_IDLE) && (w_level != '0)
                      && reader_rdy && !pause && !flush;
  assign w_push     = w_active && (r_fetchState == F_WAIT) && bram_done && !r_discard && !flush;
  assign w_flush    = w_active && flush;

  prefetch_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_dispatch),
    .flush     (w_flush),
    .push_data (bram_data),
    .head_data (w_head),
    .level     (w_level)
  );

  // A flush while a read is in flight marks its returning word for discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchState <= F_IDLE;
      r_discard    <= 1'b0;
    end else if (clk_en) begin
      case (r_fetchState)
        F_IDLE: begin
          if (w_fetch) begin
            r_fetchState <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (bram_done) begin
            r_fetchState <= F_IDLE;
            r_discard    <= 1'b0;
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        default: r_fetchState <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dispState  <= D_IDLE;
      r_readerData <= '0;
    end else if (clk_en) begin
      case (r_dispState)
        D_IDLE: begin
          if (w_dispatch) begin
            r_dispState  <= D_BUSY;
            r_readerData <= w_head;
          end
        end
        D_BUSY: begin
          if (reader_done) begin
            r_dispState <= D_IDLE;
          end
        end
        default: r_dispState <= D_IDLE;
      endcase
    end
  end

  // The head is presented alongside the trigger, then held in r_readerData until reader_done.
  assign bram_trigger   = w_fetch;
  assign reader_trigger = w_dispatch;
  assign reader_data    = w_dispatch ? w_head : r_readerData;
  assign level          = LEVEL_BITS'(w_level);
  assign idle           = (w_level == '0) && (r_fetchState == F_IDLE) && (r_dispState == D_IDLE);

endmodule

// File: tb/tb_bram_prefetch_reader.sv
// Scoreboard bench for bram_prefetch_reader: a BRAM controller model and a consumer
// model drive the DUT while dispatched words are checked in FIFO order.
module tb_bram_prefetch_reader;

  localparam int DATA_BITS  = 64;
  localparam int DEPTH      = 4;
  localparam int LEVEL_BITS = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  clk_en = 1'b1;
  logic                  is_empty = 1'b1;
  logic                  bram_rdy = 1'b0;
  logic                  bram_done = 1'b0;
  logic [DATA_BITS-1:0]  bram_data = '0;
  logic                  bram_trigger;
  logic                  reader_rdy = 1'b0;
  logic                  reader_done = 1'b0;
  logic                  reader_trigger;
  logic [DATA_BITS-1:0]  reader_data;
  logic                  pause = 1'b0;
  logic                  flush = 1'b0;
  logic [LEVEL_BITS-1:0] level;
  logic                  idle;

  bram_prefetch_reader #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH      (DEPTH),
    .LEVEL_BITS (LEVEL_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .is_empty       (is_empty),
    .bram_rdy       (bram_rdy),
    .bram_done      (bram_done),
    .bram_data      (bram_data),
    .bram_trigger   (bram_trigger),
    .reader_rdy     (reader_rdy),
    .reader_done    (reader_done),
    .reader_trigger (reader_trigger),
    .reader_data    (reader_data),
    .pause          (pause),
    .flush          (flush),
    .level          (level),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [63:0] expQ[$];
  int          cycleNum = 0;
  int          rowsLoaded = 0;
  int          nextIdx = 0;
  int          doneIdx = 0;
  int          bramCnt = 0;
  int          bramLat = 2;
  int          consLat = 2;
  int          busyCnt = 0;
  bit          consBusy = 0;
  bit          consEnable = 0;
  bit          bramRdyEn = 1;
  bit          pauseReq = 0;
  bit          flushReq = 0;
  bit          resetReq = 0;
  bit          dropNext = 0;
  bit          randLat = 0;
  int          trigCount = 0;
  int          dispCount = 0;
  int          doneCycle = 0;
  int          dispCycle = 0;
  logic [63:0] lastData = '0;

  function automatic logic [63:0] rowData(int i);
    return {32'hC12C_1E00 ^ 32'(i * 7), 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock: drive models at posedge+1, sample DUT at posedge+3.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cycleNum++;
    bram_done   = 1'b0;
    reader_done = 1'b0;
    if (bramCnt > 0) begin
      bramCnt--;
      if (bramCnt == 0) begin
        bram_done = 1'b1;
        bram_data = rowData(doneIdx);
        doneCycle = cycleNum;
        if (dropNext || flushReq || resetReq) dropNext = 0;
        else expQ.push_back(rowData(doneIdx));
      end
    end
    flush = flushReq;
    if (flushReq) begin
      expQ.delete();
      if (bramCnt > 0) dropNext = 1;
      flushReq = 0;
    end
    reset = resetReq;
    if (resetReq) begin
      expQ.delete();
      consBusy = 0;
      dropNext = (bramCnt > 0);
    end
    if (consBusy) begin
      busyCnt--;
      if (busyCnt == 0) begin
        reader_done = 1'b1;
        consBusy = 0;
      end
    end
    reader_rdy = consEnable && !consBusy;
    pause      = pauseReq;
    bram_rdy   = bramRdyEn;
    is_empty   = (nextIdx >= rowsLoaded);
    #2;
    if (bram_trigger) begin
      trigCount++;
      checkOutput("one_outstanding", 64'(bramCnt == 0), 64'd1);
      checkOutput("fetch_room", 64'(level < DEPTH), 64'd1);
      doneIdx = nextIdx;
      nextIdx++;
      bramCnt = randLat ? int'($urandom_range(1, 3)) : bramLat;
    end
    if (reader_trigger) begin
      dispCount++;
      dispCycle = cycleNum;
      checkOutput("dispatch_has_expect", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) checkOutput("dispatch_data", reader_data, expQ.pop_front());
      lastData = reader_data;
      consBusy = 1;
      busyCnt  = (randLat ? int'($urandom_range(0, 3)) : consLat) + 1;
    end else if (consBusy) begin
      checkOutput("data_stable", reader_data, lastData);
    end
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      if (nextIdx >= rowsLoaded && bramCnt == 0 && expQ.size() == 0 && !consBusy) break;
      applyStimulus();
    end
    checkOutput({tag, "_drain_in_time"}, 64'(k < bound), 64'd1);
    applyStimulus();
    checkOutput({tag, "_idle"}, 64'(idle), 64'd1);
    checkOutput({tag, "_level_zero"}, 64'(level), 64'd0);
  endtask

  initial begin
    int k;
    int d0;
    int droppedIdx;

    // Reset state
    resetReq = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_bram_trigger", 64'(bram_trigger), 64'd0);
    checkOutput("rst_reader_trigger", 64'(reader_trigger), 64'd0);
    checkOutput("rst_reader_data", reader_data, 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    resetReq = 0;
    applyStimulus();
    checkOutput("post_rst_idle", 64'(idle), 64'd1);

    // Single word into an empty queue: dispatch lands the cycle after bram_done
    consEnable = 1;
    rowsLoaded += 1;
    for (k = 0; k < 50 && dispCount == 0; k++) applyStimulus();
    checkOutput("first_dispatch_in_time", 64'(k < 50), 64'd1);
    checkOutput("no_bypass_latency", 64'(dispCycle - doneCycle), 64'd1);
    drain("single", 100);

    // Stalled consumer: queue fills to DEPTH and fetching stops
    consEnable = 0;
    trigCount = 0;
    rowsLoaded += 10;
    for (k = 0; k < 30; k++) applyStimulus();
    checkOutput("stall_trigger_count", 64'(trigCount), 64'(DEPTH));
    checkOutput("stall_level_full", 64'(level), 64'(DEPTH));
    consEnable = 1;
    drain("stall", 500);

    // Pause holds dispatch while the queue has two words
    pauseReq = 1;
    rowsLoaded += 2;
    for (k = 0; k < 50 && level != 2; k++) applyStimulus();
    checkOutput("pause_fill_level", 64'(level), 64'd2);
    d0 = dispCount;
    for (k = 0; k < 20; k++) applyStimulus();
    checkOutput("pause_no_dispatch", 64'(dispCount - d0), 64'd0);
    pauseReq = 0;
    applyStimulus();
    checkOutput("pause_release_dispatch", 64'(dispCount - d0), 64'd1);
    drain("pause", 200);

    // Flush with three queued words and a fourth read in flight
    consEnable = 0;
    bramLat = 5;
    rowsLoaded += 8;
    for (k = 0; k < 100 && !(level == 3 && bramCnt > 0); k++) applyStimulus();
    checkOutput("flush_setup_level", 64'(level), 64'd3);
    droppedIdx = doneIdx;
    flushReq = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("flush_level_zero", 64'(level), 64'd0);
    consEnable = 1;
    d0 = dispCount;
    for (k = 0; k < 100 && dispCount == d0; k++) applyStimulus();
    checkOutput("flush_next_word", lastData, rowData(droppedIdx + 1));
    drain("flush", 500);

    // Reset while the consumer is busy and a BRAM read is outstanding
    bramLat = 4;
    consLat = 10;
    rowsLoaded += 6;
    for (k = 0; k < 100 && !(consBusy && bramCnt > 0); k++) applyStimulus();
    checkOutput("rst_mid_setup", 64'(consBusy && bramCnt > 0), 64'd1);
    resetReq = 1;
    bramRdyEn = 0;
    applyStimulus();
    checkOutput("rst_mid_bram_trigger", 64'(bram_trigger), 64'd0);
    checkOutput("rst_mid_reader_trigger", 64'(reader_trigger), 64'd0);
    resetReq = 0;
    applyStimulus();
    checkOutput("rst_mid_reader_data", reader_data, 64'd0);
    checkOutput("rst_mid_level", 64'(level), 64'd0);
    checkOutput("rst_mid_idle", 64'(idle), 64'd1);
    d0 = dispCount;
    for (k = 0; k < 20 && bramCnt > 0; k++) applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("late_done_ignored_level", 64'(level), 64'd0);
    checkOutput("late_done_no_dispatch", 64'(dispCount - d0), 64'd0);
    bramRdyEn = 1;
    consLat = 2;
    drain("after_reset", 500);

    // Long run: 314 rows with random BRAM and consumer latencies
    randLat = 1;
    d0 = dispCount;
    rowsLoaded += 314;
    drain("bulk", 6000);
    checkOutput("bulk_count", 64'(dispCount - d0), 64'd314);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
